// File: rtl/t05_cb_walker.sv
// Huffman codebook walker: depth-first, left-first walk of the built tree,
// emitting one {char, code, len} codeword per character leaf.
module t05_cb_walker #(
    parameter int CODE_W = 16,
    parameter int LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CB_en,
    input  logic [6:0]        root_idx,
    output logic              rd_req,
    output logic [6:0]        rd_addr,
    input  logic [70:0]       rd_data,
    input  logic              rd_valid,
    output logic              cw_valid,
    input  logic              cw_ready,
    output logic [7:0]        cw_char,
    output logic [CODE_W-1:0] cw_code,
    output logic [LEN_W-1:0]  cw_len,
    output logic              CB_finished,
    output logic              ERROR,
    output logic [2:0]        state_reg
);
    localparam int SP_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [8:0] CHILD_NULL = 9'h180;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXAM  = 3'd2,
        EMIT  = 3'd3,
        ADV   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t            state, state_nxt;
    logic [SP_W-1:0]   sp;
    logic [6:0]        stack_idx [CODE_W];
    logic [CODE_W-1:0] side;
    logic              returning;
    logic [17:0]       node_kids;
    logic [8:0]        child;
    logic              child_null, child_leaf;
    logic [CODE_W-1:0] code_nxt;
    logic [6:0]        fetch_addr_nxt;
    logic              unused_sum;

    // Only the two child pointers are needed once the index has been checked.
    assign unused_sum = ^rd_data[45:0];
    assign state_reg  = state;

    always_comb begin
        child      = side[sp] ? node_kids[8:0] : node_kids[17:9];
        child_null = (child == CHILD_NULL);
        child_leaf = ~child[8];
        // Shift in side[0] first so the root decision lands at bit len-1.
        code_nxt = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (i <= int'(sp)) code_nxt = {code_nxt[CODE_W-2:0], side[i]};
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_addr_nxt = rd_addr;
        case (state)
            IDLE: if (CB_en) begin
                state_nxt      = FETCH;
                fetch_addr_nxt = root_idx;
            end
            FETCH: if (rd_valid) begin
                if (rd_data[70:64] != rd_addr) state_nxt = ERR;
                else if (returning)            state_nxt = ADV;
                else                           state_nxt = EXAM;
            end
            EXAM: begin
                if (child_null)                   state_nxt = ADV;
                else if (child_leaf)              state_nxt = EMIT;
                else if (int'(sp) + 2 > CODE_W)   state_nxt = ERR;
                else begin
                    state_nxt      = FETCH;
                    fetch_addr_nxt = child[6:0];
                end
            end
            EMIT: if (cw_ready) state_nxt = ADV;
            ADV: begin
                if (!side[sp])    state_nxt = EXAM;
                else if (sp == '0) state_nxt = DONE;
                else begin
                    state_nxt      = FETCH;
                    fetch_addr_nxt = stack_idx[sp - SP_W'(1)];
                end
            end
            DONE:    if (!CB_en) state_nxt = IDLE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sp          <= '0;
            side        <= '0;
            returning   <= 1'b0;
            node_kids   <= '0;
            for (int i = 0; i < CODE_W; i++) stack_idx[i] <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            cw_valid    <= 1'b0;
            cw_char     <= '0;
            cw_code     <= '0;
            cw_len      <= '0;
            CB_finished <= 1'b0;
            ERROR       <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_req      <= (state_nxt == FETCH);
            rd_addr     <= fetch_addr_nxt;
            cw_valid    <= (state_nxt == EMIT);
            CB_finished <= (state_nxt == DONE);
            ERROR       <= (state_nxt == ERR);
            case (state)
                IDLE: if (CB_en) begin
                    stack_idx[0] <= root_idx;
                    side[0]      <= 1'b0;
                    sp           <= '0;
                    returning    <= 1'b0;
                end
                FETCH: if (rd_valid) begin
                    node_kids <= rd_data[63:46];
                    returning <= 1'b0;
                end
                EXAM: begin
                    if (state_nxt == EMIT) begin
                        cw_char <= child[7:0];
                        cw_code <= code_nxt;
                        cw_len  <= LEN_W'(int'(sp) + 1);
                    end else if (state_nxt == FETCH) begin
                        sp                         <= sp + SP_W'(1);
                        stack_idx[sp + SP_W'(1)]   <= child[6:0];
                        side[sp + SP_W'(1)]        <= 1'b0;
                    end
                end
                ADV: begin
                    if (!side[sp]) side[sp] <= 1'b1;
                    else if (state_nxt == FETCH) begin
                        sp        <= sp - SP_W'(1);
                        returning <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/t05_cb_walker.md
# t05_cb_walker

Codebook walker for the Huffman path: the read-side counterpart of the tree builder. Once the builder has written all 71-bit nodes to tree memory, this block walks the tree depth-first from the root. For every character leaf it emits one codeword (character, code bits, length), which the codebook/encoder stage consumes. Tree memory is reached through a request/valid read port with variable latency.

## Interface
Parameters:
- CODE_W, 16: maximum codeword length in bits; also the walk-stack depth.
- LEN_W, $clog2(CODE_W+1): width of the length output.

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- CB_en  in  1  start level; sampled in IDLE
- root_idx  in  7  index of the root node (last node index written by the builder)
- rd_req  out  1  tree-memory read request
- rd_addr  out  7  node index to read
- rd_data  in  71  node word: {idx[70:64], left[63:55], right[54:46], sum[45:0]}
- rd_valid  in  1  rd_data valid; honoured only while rd_req=1
- cw_valid  out  1  codeword valid
- cw_ready  in  1  consumer accepts codeword
- cw_char  out  8  leaf character
- cw_code  out  CODE_W  code, right-aligned; root decision at bit len-1, leaf decision at bit 0, upper bits 0
- cw_len  out  LEN_W  code length, 1..CODE_W
- CB_finished  out  1  walk complete
- ERROR  out  1  sticky fault flag
- state_reg  out  3  current state

## Operation
- Child encoding (9 bits):
  - bit8=0: character leaf, char=[7:0].
  - 9'b110000000: null.
  - Otherwise bit8=1: internal node, index=[6:0].
- Stack: CODE_W entries of {node idx[6:0], side bit}, plus a stack pointer sp. The current depth is sp; path bit i is side[i].
- States: IDLE=0, FETCH=1, EXAM=2, EMIT=3, ADV=4, DONE=5, ERR=6.
- IDLE:
  - When CB_en=1: stack[0]={root_idx,0}, sp=0, returning=0.
  - Go to FETCH.
- FETCH:
  - rd_req=1, rd_addr=stack[sp].idx.
  - On rd_valid: latch rd_data into node_reg.
  - If rd_data[70:64] != rd_addr, go to ERR.
  - Else go to ADV if returning=1, or EXAM if returning=0; clear returning either way.
- EXAM: child = side[sp] ? node_reg.right : node_reg.left.
  - Null child: go to ADV.
  - Leaf: form the code from side[0..sp], length sp+1; go to EMIT.
  - Internal child with sp+2 > CODE_W: go to ERR.
  - Internal child otherwise: sp=sp+1, stack[sp]={child idx,0}; go to FETCH.
- EMIT: hold cw_valid=1 and stable data until cw_ready=1 at a clock edge, then go to ADV.
- ADV:
  - If side[sp]=0: set side[sp]=1 and go to EXAM, reusing node_reg with no re-read.
  - Else if sp=0: go to DONE.
  - Else: sp=sp-1, returning=1; go to FETCH to re-read the parent.
- DONE:
  - CB_finished=1 while in DONE.
  - Return to IDLE when CB_en=0.
- ERR:
  - ERROR=1 and all handshakes deasserted.
  - Only rst leaves ERR.
- Degenerate trees:
  - Root with both children null: no codewords; goes to DONE.
  - Single-leaf root (leaf left, null right): leaf gets code 0, len 1.
- Leaves are emitted in left-first preorder.

## Timing
- Reset values: rd_req=0, rd_addr=0, cw_valid=0, cw_char=0, cw_code=0, cw_len=0, CB_finished=0, ERROR=0, state_reg=0, sp=0.
- Reset mid-operation: state returns to IDLE at the reset edge. Any in-flight read or codeword is abandoned; a late rd_valid is ignored.
- rd_req is registered and high for every FETCH cycle.
  - rd_addr is stable while rd_req=1.
  - rd_valid may arrive in the first FETCH cycle (zero-wait) or any later cycle.
  - rd_valid outside FETCH is ignored.
- Zero-wait latency from CB_en sampled in IDLE to the first cw_valid is 3 cycles: IDLE→FETCH→EXAM→EMIT.
- The codeword transfer completes on the edge where cw_valid=1 and cw_ready=1. cw_valid is 0 in the next cycle (ADV), so there are never back-to-back transfers.
- Read count equals the number of internal nodes plus the number of pops. Each node is read once on descent plus once per return to it.
- CB_en held high after DONE keeps CB_finished=1; a new walk needs CB_en low for at least one cycle.

## Test plan
- Two leaves: node0={0,'A','B',120}, root_idx=0 → (A,0,len1), (B,1,len1); exactly 1 read; CB_finished=1.
- Three levels: node0={0,'A','B'}, node1={1,'C',9'h100}, root_idx=1 → (C,0,1), (A,10b,2), (B,11b,2); reads at addr 1,0,1.
- Degenerate trees: root {0,'D',null} → one codeword (D,0,1); root {0,null,null} → zero codewords, CB_finished=1.
- Backpressure: Test 2 tree with rd_valid delayed 3 cycles and cw_ready held low 5 cycles per codeword → rd_addr and cw_* remain stable; results identical to Test 2.
- Faults:
  - Request addr 1, return idx 2 → ERROR=1, state_reg=6, rd_req=0; ERROR stays set until rst.
  - CODE_W=4 with a left chain 4 internal nodes deep → ERROR asserted before any length-5 codeword.
- Reset during EMIT: all outputs are at reset values the cycle after the rst edge; re-enabling with the Test 2 tree gives the full, correct sequence.
